jt51_csr_ch_bank: RTL and testbench
===================================

Name: jt51_csr_ch_bank

Overview:
- Parametrised channel-register bank. Successor to the fixed 8-channel per-channel CSR shift store.
- Holds the 26-bit per-channel field word (rl, fb, con, kc, kf, ams, pms) for CH channels in a circular shift register advanced by cen.
- Adds addressed writes: a request is queued until its target channel's slot comes round, then merged and acknowledged.
- Adds addressed readback of any channel. Sits between the register-write decoder and the operator/phase pipeline.

Parameters:
- CH, 8, number of channels (2..16); sets the shift depth.
- CHW, 4, slot/channel index width; ceil(log2(CH)) or larger.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; one slot advance per cen cycle
- din  in  8  write data byte
- wr_req  in  1  write request, sampled when busy=0
- wr_ch  in  CHW  target channel of write
- wr_sel  in  7  field update mask {rl,fb,con,kc,kf,ams,pms}; bit6 = rl
- busy  out  1  write pending
- wr_ack  out  1  one-clk pulse when a write retires
- rd_req  in  1  readback request, sampled when rd_busy=0
- rd_ch  in  CHW  channel to read
- rd_busy  out  1  readback pending
- rd_valid  out  1  one-clk pulse; rd_data valid
- rd_data  out  26  {rl,fb,con,kc,kf,ams,pms} of rd_ch
- slot  out  CHW  channel currently presented on field outputs
- rl 2, fb 3, con 3, kc 7, kf 6, ams 2, pms 3  out  current-slot fields, the same slices of the shift output

Behaviour:
- Reset: all CH entries 0; slot=0; busy, wr_ack, rd_busy, rd_valid = 0; rd_data = 0; all field outputs 0. Reset mid-request discards the pending write/read with no ack.
- Storage: CH-stage 26-bit shift register. Output stage = entry of channel slot. On cen: the merged word is shifted in, and slot increments, wrapping CH-1 -> 0. Without cen: nothing moves.
- Field slicing from din:
  - rl = din[7:6], fb = din[5:3], con = din[2:0]
  - kc = din[6:0], kf = din[7:2]
  - ams = din[1:0], pms = din[6:4]
- Merge word: each field takes the din slice if the pending write targets slot, cen=1 and its wr_sel bit is set; otherwise it recirculates from the output stage.
- Write handshake:
  - wr_req with busy=0 and wr_ch<CH latches din, wr_ch and wr_sel; busy=1 next clk.
  - Retire happens on the first cen clock with busy=1 and slot==pending ch. In that clock the merge is applied. Next clk: busy=0 and wr_ack=1 for one clk.
  - Latency from acceptance: 1..CH cen cycles.
  - wr_req while busy=1 is ignored; the requester holds it.
  - On the retire clock busy is still 1, so a new wr_req is accepted on the following clk.
  - wr_ch>=CH: not latched; wr_ack pulses next clk with no storage change.
  - wr_sel=0: waits for its slot, retires, no change.
- Read handshake:
  - rd_req with rd_busy=0 latches rd_ch; rd_busy=1.
  - Completes on the first cen clock with slot==rd_ch. rd_data captures the merge word, so a same-cycle write to that channel is visible.
  - Next clk: rd_busy=0 and rd_valid=1 for one clk. rd_data holds until the next capture.
  - rd_ch>=CH: rd_valid pulses next clk, rd_data=0.
  - Reads and writes are independent and may be pending together.
- Field outputs always equal the output-stage entry; they change only on cen or rst.

Test Plan:
- Reset then 2*CH cen cycles -> all fields 0, slot runs 0..7 and wraps to 0, busy=0, no acks.
- CH=8, slot=2, write ch5 din=8'hC7 wr_sel=7'b1110000 -> wr_ack after the 3rd cen; ch5 then shows rl=3, fb=0, con=7; kc/kf/ams/pms unchanged at 0.
- Write ch3 kc din=8'h4A wr_sel=7'b0001000, second wr_req held while busy -> second accepted only after wr_ack; ch3 kc=7'h4A persists across 3 full rotations.
- Write and read of ch1 pending together (din=8'h38, wr_sel fb) -> rd_valid in the same clk as wr_ack; rd_data fb field = 3'd7.
- Write accepted, rst asserted before its slot -> no wr_ack, busy=0, ch stays 0.
- CH=5: slot wraps 4 -> 0; write ch4 retires; write to ch6 -> immediate wr_ack, no entry changes.

Source files
------------

// File: rtl/jt51_csr_ch_bank.sv
// Per-channel register bank: CH-deep circular store of the 26-bit channel word,
// with queued addressed writes that merge when their slot comes round, and addressed readback.
module jt51_csr_ch_bank #(
    parameter int CH  = 8,
    parameter int CHW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic [7:0]     din,
    input  logic           wr_req,
    input  logic [CHW-1:0] wr_ch,
    input  logic [6:0]     wr_sel,
    output logic           busy,
    output logic           wr_ack,
    input  logic           rd_req,
    input  logic [CHW-1:0] rd_ch,
    output logic           rd_busy,
    output logic           rd_valid,
    output logic [25:0]    rd_data,
    output logic [CHW-1:0] slot,
    output logic [1:0]     rl,
    output logic [2:0]     fb,
    output logic [2:0]     con,
    output logic [6:0]     kc,
    output logic [5:0]     kf,
    output logic [1:0]     ams,
    output logic [2:0]     pms
);
    localparam logic [CHW:0]   CH_L = (CHW+1)'(CH);
    localparam logic [CHW-1:0] LAST = CHW'(CH - 1);

    logic [25:0]    mem_q [CH];
    logic [CHW-1:0] slot_q, slot_d;
    logic           wbusy_q, wack_q;
    logic [CHW-1:0] wch_q;
    logic [7:0]     wdin_q;
    logic [6:0]     wsel_q;
    logic           rbusy_q, rvld_q;
    logic [CHW-1:0] rch_q;
    logic [25:0]    rdata_q;
    logic [25:0]    cur, merged;
    logic           wr_hit, rd_hit, wr_in_range, rd_in_range;

    // Word layout {rl[25:24], fb[23:21], con[20:18], kc[17:11], kf[10:5], ams[4:3], pms[2:0]}
    function automatic logic [25:0] merge_word(input logic [25:0] w_in, input logic [7:0] d,
                                               input logic [6:0] sel);
        logic [25:0] w;
        w = w_in;
        if (sel[6]) w[25:24] = d[7:6];
        if (sel[5]) w[23:21] = d[5:3];
        if (sel[4]) w[20:18] = d[2:0];
        if (sel[3]) w[17:11] = d[6:0];
        if (sel[2]) w[10:5]  = d[7:2];
        if (sel[1]) w[4:3]   = d[1:0];
        if (sel[0]) w[2:0]   = d[6:4];
        return w;
    endfunction

    assign cur         = mem_q[0];
    assign wr_hit      = cen && wbusy_q && (wch_q == slot_q);
    assign rd_hit      = cen && rbusy_q && (rch_q == slot_q);
    assign merged      = wr_hit ? merge_word(cur, wdin_q, wsel_q) : cur;
    assign wr_in_range = ({1'b0, wr_ch} < CH_L);
    assign rd_in_range = ({1'b0, rd_ch} < CH_L);

    always_comb begin
        slot_d = slot_q;
        if (cen) slot_d = (slot_q == LAST) ? '0 : slot_q + 1'b1;
    end

    // Index 0 is the output stage; the merged word re-enters at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) mem_q[i] <= '0;
            slot_q <= '0;
        end else if (cen) begin
            for (int i = 0; i < CH - 1; i++) mem_q[i] <= mem_q[i+1];
            mem_q[CH-1] <= merged;
            slot_q      <= slot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbusy_q <= 1'b0;
            wack_q  <= 1'b0;
        end else begin
            wack_q <= wr_hit;
            if (wr_hit) begin
                wbusy_q <= 1'b0;
            end else if (!wbusy_q && wr_req) begin
                if (wr_in_range) wbusy_q <= 1'b1;
                else             wack_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!wbusy_q && wr_req && wr_in_range) begin
            wch_q  <= wr_ch;
            wdin_q <= din;
            wsel_q <= wr_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbusy_q <= 1'b0;
            rvld_q  <= 1'b0;
            rch_q   <= '0;
            rdata_q <= '0;
        end else begin
            rvld_q <= rd_hit;
            if (rd_hit) begin
                rbusy_q <= 1'b0;
                rdata_q <= merged;
            end else if (!rbusy_q && rd_req) begin
                if (rd_in_range) begin
                    rbusy_q <= 1'b1;
                    rch_q   <= rd_ch;
                end else begin
                    rvld_q  <= 1'b1;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign busy     = wbusy_q;
    assign wr_ack   = wack_q;
    assign rd_busy  = rbusy_q;
    assign rd_valid = rvld_q;
    assign rd_data  = rdata_q;
    assign slot     = slot_q;
    assign rl       = cur[25:24];
    assign fb       = cur[23:21];
    assign con      = cur[20:18];
    assign kc       = cur[17:11];
    assign kf       = cur[10:5];
    assign ams      = cur[4:3];
    assign pms      = cur[2:0];
endmodule

// File: tb/tb_jt51_csr_ch_bank.sv
// Bench for jt51_csr_ch_bank: an 8-channel and a 5-channel instance checked every cycle
// against a channel-indexed field model, plus directed scenarios with literal expectations.
module tb_jt51_csr_ch_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cen_a    [2];
    logic [7:0] din_a    [2];
    logic       wr_req_a [2];
    logic [3:0] wr_ch_a  [2];
    logic [6:0] wr_sel_a [2];
    logic       rd_req_a [2];
    logic [3:0] rd_ch_a  [2];

    logic        busy_w [2], wr_ack_w [2], rd_busy_w [2], rd_valid_w [2];
    logic [25:0] rd_data_w [2];
    logic [3:0]  slot_w [2];
    logic [1:0]  rl_w [2], ams_w [2];
    logic [2:0]  fb_w [2], con_w [2], pms_w [2];
    logic [6:0]  kc_w [2];
    logic [5:0]  kf_w [2];
    logic [25:0] fld_w [2];

    assign fld_w[0] = {rl_w[0], fb_w[0], con_w[0], kc_w[0], kf_w[0], ams_w[0], pms_w[0]};
    assign fld_w[1] = {rl_w[1], fb_w[1], con_w[1], kc_w[1], kf_w[1], ams_w[1], pms_w[1]};

    jt51_csr_ch_bank #(.CH(8), .CHW(4)) u8 (
        .clk(clk), .rst(rst), .cen(cen_a[0]), .din(din_a[0]),
        .wr_req(wr_req_a[0]), .wr_ch(wr_ch_a[0]), .wr_sel(wr_sel_a[0]),
        .busy(busy_w[0]), .wr_ack(wr_ack_w[0]),
        .rd_req(rd_req_a[0]), .rd_ch(rd_ch_a[0]), .rd_busy(rd_busy_w[0]),
        .rd_valid(rd_valid_w[0]), .rd_data(rd_data_w[0]), .slot(slot_w[0]),
        .rl(rl_w[0]), .fb(fb_w[0]), .con(con_w[0]), .kc(kc_w[0]), .kf(kf_w[0]),
        .ams(ams_w[0]), .pms(pms_w[0])
    );

    jt51_csr_ch_bank #(.CH(5), .CHW(4)) u5 (
        .clk(clk), .rst(rst), .cen(cen_a[1]), .din(din_a[1]),
        .wr_req(wr_req_a[1]), .wr_ch(wr_ch_a[1]), .wr_sel(wr_sel_a[1]),
        .busy(busy_w[1]), .wr_ack(wr_ack_w[1]),
        .rd_req(rd_req_a[1]), .rd_ch(rd_ch_a[1]), .rd_busy(rd_busy_w[1]),
        .rd_valid(rd_valid_w[1]), .rd_data(rd_data_w[1]), .slot(slot_w[1]),
        .rl(rl_w[1]), .fb(fb_w[1]), .con(con_w[1]), .kc(kc_w[1]), .kf(kf_w[1]),
        .ams(ams_w[1]), .pms(pms_w[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-channel field records addressed by channel number
    typedef struct {
        int rl, fb, con, kc, kf, ams, pms;
    } fld_t;

    fld_t        mm [2][16];
    int          m_slot [2];
    bit          m_wb [2], m_ack [2], m_rb [2], m_rv [2];
    int          m_wch [2], m_wdin [2], m_wsel [2], m_rch [2];
    logic [25:0] m_rdata [2];
    bit          mstarted = 1'b0;

    function automatic fld_t apply_write(input fld_t f_in, input int d, input int sel);
        fld_t f;
        f = f_in;
        if (sel & 64) f.rl  = (d >> 6) & 3;
        if (sel & 32) f.fb  = (d >> 3) & 7;
        if (sel & 16) f.con = d & 7;
        if (sel & 8)  f.kc  = d & 127;
        if (sel & 4)  f.kf  = (d >> 2) & 63;
        if (sel & 2)  f.ams = d & 3;
        if (sel & 1)  f.pms = (d >> 4) & 7;
        return f;
    endfunction

    function automatic logic [25:0] pack(input fld_t f);
        return {2'(f.rl), 3'(f.fb), 3'(f.con), 7'(f.kc), 6'(f.kf), 2'(f.ams), 3'(f.pms)};
    endfunction

    always @(posedge clk) begin
        int n;
        bit owb, orb;
        for (int k = 0; k < 2; k++) begin
            n = (k == 1) ? 5 : 8;
            if (rst) begin
                mstarted = 1'b1;
                for (int c = 0; c < 16; c++) mm[k][c] = '{0, 0, 0, 0, 0, 0, 0};
                m_slot[k] = 0; m_wb[k] = 0; m_ack[k] = 0; m_rb[k] = 0; m_rv[k] = 0;
                m_rdata[k] = '0;
            end else begin
                owb = m_wb[k];
                orb = m_rb[k];
                m_ack[k] = 0;
                m_rv[k]  = 0;
                if (cen_a[k]) begin
                    if (owb && m_wch[k] == m_slot[k]) begin
                        mm[k][m_slot[k]] = apply_write(mm[k][m_slot[k]], m_wdin[k], m_wsel[k]);
                        m_ack[k] = 1;
                        m_wb[k]  = 0;
                    end
                    if (orb && m_rch[k] == m_slot[k]) begin
                        m_rdata[k] = pack(mm[k][m_slot[k]]);
                        m_rv[k] = 1;
                        m_rb[k] = 0;
                    end
                    m_slot[k] = (m_slot[k] + 1) % n;
                end
                if (!owb && wr_req_a[k]) begin
                    if (int'(wr_ch_a[k]) < n) begin
                        m_wb[k] = 1; m_wch[k] = int'(wr_ch_a[k]);
                        m_wdin[k] = int'(din_a[k]); m_wsel[k] = int'(wr_sel_a[k]);
                    end else m_ack[k] = 1;
                end
                if (!orb && rd_req_a[k]) begin
                    if (int'(rd_ch_a[k]) < n) begin
                        m_rb[k] = 1; m_rch[k] = int'(rd_ch_a[k]);
                    end else begin
                        m_rv[k] = 1; m_rdata[k] = '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mstarted) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.slot", k), 32'(slot_w[k]), 32'(m_slot[k]));
                chk($sformatf("u%0d.fields", k), 32'(fld_w[k]), 32'(pack(mm[k][m_slot[k]])));
                chk($sformatf("u%0d.busy", k), 32'(busy_w[k]), 32'(m_wb[k]));
                chk($sformatf("u%0d.wr_ack", k), 32'(wr_ack_w[k]), 32'(m_ack[k]));
                chk($sformatf("u%0d.rd_busy", k), 32'(rd_busy_w[k]), 32'(m_rb[k]));
                chk($sformatf("u%0d.rd_valid", k), 32'(rd_valid_w[k]), 32'(m_rv[k]));
                chk($sformatf("u%0d.rd_data", k), 32'(rd_data_w[k]), 32'(m_rdata[k]));
            end
        end
    end

    task automatic wait_slot(input int k, input int s);
        int i;
        i = 0;
        while (int'(slot_w[k]) != s && i < 64) begin
            @(negedge clk);
            i++;
        end
        if (i >= 64) chk($sformatf("u%0d.wait_slot%0d_timeout", k, s), 32'(0), 32'(1));
    endtask

    task automatic wait_ack(input int k);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!wr_ack_w[k] && i < 40);
        if (!wr_ack_w[k]) chk($sformatf("u%0d.wait_ack_timeout", k), 32'(0), 32'(1));
    endtask

    initial begin
        int  i;
        bit  seen;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cen_a[k] = 1'b1; din_a[k] = '0; wr_req_a[k] = 1'b0; wr_ch_a[k] = '0;
            wr_sel_a[k] = '0; rd_req_a[k] = 1'b0; rd_ch_a[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset.slot", 32'(slot_w[0]), 32'(0));
        chk("reset.fields", 32'(fld_w[0]), 32'(0));
        chk("reset.busy", 32'(busy_w[0]), 32'(0));
        chk("reset.rd_busy", 32'(rd_busy_w[0]), 32'(0));
        chk("reset.rd_valid", 32'(rd_valid_w[0]), 32'(0));
        chk("reset.rd_data", 32'(rd_data_w[0]), 32'(0));
        rst = 1'b0;

        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk("rot.slot", 32'(slot_w[0]), 32'(c % 8));
            chk("rot.fields", 32'(fld_w[0]), 32'(0));
            chk("rot.wr_ack", 32'(wr_ack_w[0]), 32'(0));
        end

        // Field write of rl/fb/con to ch5 issued while slot 2 is presented
        wait_slot(0, 2);
        wr_ch_a[0] = 4'd5; din_a[0] = 8'hC7; wr_sel_a[0] = 7'b1110000; wr_req_a[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            wr_req_a[0] = 1'b0;
            chk("t2.no_early_ack", 32'(wr_ack_w[0]), 32'(0));
        end
        @(negedge clk);
        chk("t2.ack", 32'(wr_ack_w[0]), 32'(1));
        wait_slot(0, 5);
        chk("t2.ch5_rl", 32'(rl_w[0]), 32'(3));
        chk("t2.ch5_fb", 32'(fb_w[0]), 32'(0));
        chk("t2.ch5_con", 32'(con_w[0]), 32'(7));
        chk("t2.ch5_rest", 32'({kc_w[0], kf_w[0], ams_w[0], pms_w[0]}), 32'(0));

        // kc write to ch3 with a second request held behind it
        @(negedge clk);
        wr_ch_a[0] = 4'd3; din_a[0] = 8'h4A; wr_sel_a[0] = 7'b0001000; wr_req_a[0] = 1'b1;
        @(negedge clk);
        chk("t3.accept_busy", 32'(busy_w[0]), 32'(1));
        wr_ch_a[0] = 4'd7; din_a[0] = 8'h03; wr_sel_a[0] = 7'b0000010;
        i = 0;
        while (!wr_ack_w[0] && i < 20) begin
            chk("t3.held_busy", 32'(busy_w[0]), 32'(1));
            @(negedge clk);
            i++;
        end
        chk("t3.first_ack", 32'(wr_ack_w[0]), 32'(1));
        chk("t3.busy_at_ack", 32'(busy_w[0]), 32'(0));
        @(negedge clk);
        chk("t3.second_accept", 32'(busy_w[0]), 32'(1));
        wr_req_a[0] = 1'b0;
        wait_ack(0);
        repeat (3) begin
            wait_slot(0, 3);
            chk("t3.ch3_kc", 32'(kc_w[0]), 32'(7'h4A));
            @(negedge clk);
        end
        wait_slot(0, 7);
        chk("t3.ch7_ams", 32'(ams_w[0]), 32'(3));

        // Write and read of ch1 pending together
        wait_slot(0, 4);
        wr_ch_a[0] = 4'd1; din_a[0] = 8'h38; wr_sel_a[0] = 7'b0100000; wr_req_a[0] = 1'b1;
        rd_ch_a[0] = 4'd1; rd_req_a[0] = 1'b1;
        @(negedge clk);
        wr_req_a[0] = 1'b0; rd_req_a[0] = 1'b0;
        wait_ack(0);
        chk("t4.rd_valid_with_ack", 32'(rd_valid_w[0]), 32'(1));
        chk("t4.rd_data", 32'(rd_data_w[0]), 32'(26'h0E00000));

        // Reset while a write waits for its slot
        wait_slot(0, 0);
        wr_ch_a[0] = 4'd6; din_a[0] = 8'hFF; wr_sel_a[0] = 7'h7F; wr_req_a[0] = 1'b1;
        @(negedge clk);
        wr_req_a[0] = 1'b0;
        chk("t5.busy_before_rst", 32'(busy_w[0]), 32'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (wr_ack_w[0]) seen = 1'b1;
        end
        chk("t5.no_ack", 32'(seen), 32'(0));
        chk("t5.busy", 32'(busy_w[0]), 32'(0));
        wait_slot(0, 6);
        chk("t5.ch6_zero", 32'(fld_w[0]), 32'(0));

        // Five-channel instance: wrap, in-range write, out-of-range write
        wait_slot(1, 4);
        @(negedge clk);
        chk("ch5.wrap", 32'(slot_w[1]), 32'(0));
        wr_ch_a[1] = 4'd4; din_a[1] = 8'hFF; wr_sel_a[1] = 7'h7F; wr_req_a[1] = 1'b1;
        @(negedge clk);
        wr_req_a[1] = 1'b0;
        wait_ack(1);
        wait_slot(1, 4);
        chk("ch5.ch4_all", 32'(fld_w[1]), 32'(26'h3FFFFFF));
        wr_ch_a[1] = 4'd6; din_a[1] = 8'h55; wr_sel_a[1] = 7'h7F; wr_req_a[1] = 1'b1;
        @(negedge clk);
        wr_req_a[1] = 1'b0;
        chk("ch5.oor_ack", 32'(wr_ack_w[1]), 32'(1));
        chk("ch5.oor_busy", 32'(busy_w[1]), 32'(0));
        rd_ch_a[1] = 4'd9; rd_req_a[1] = 1'b1;
        @(negedge clk);
        rd_req_a[1] = 1'b0;
        chk("ch5.oor_rd_valid", 32'(rd_valid_w[1]), 32'(1));
        chk("ch5.oor_rd_data", 32'(rd_data_w[1]), 32'(0));

        // Randomized traffic on both instances, including cen gaps and resets
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                cen_a[k]    = ($urandom_range(0, 3) != 0);
                wr_req_a[k] = ($urandom_range(0, 2) == 0);
                wr_ch_a[k]  = 4'($urandom_range(0, (k == 1) ? 6 : 9));
                din_a[k]    = 8'($urandom);
                wr_sel_a[k] = 7'($urandom);
                rd_req_a[k] = ($urandom_range(0, 3) == 0);
                rd_ch_a[k]  = 4'($urandom_range(0, (k == 1) ? 6 : 9));
            end
        end
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
